// File: rtl/genesys_imem_pkg.sv
// Shared definitions for the instruction-memory read path: sequencer states and the
// opcode field that marks the final instruction of a block.
package genesys_imem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_BLK = 3'd1,
      ST_FETCH    = 3'd2,
      ST_DRAIN    = 3'd3,
      ST_DONE     = 3'd4
   } imem_seq_state_e;

   localparam int OPCODE_LSB = 28;
   localparam int OPCODE_W   = 4;
   localparam logic [OPCODE_W-1:0] BLOCK_END_OPCODE = 4'hF;

   function automatic logic is_block_end(input logic [OPCODE_W-1:0] opcode);
      return opcode == BLOCK_END_OPCODE;
   endfunction

endpackage

// File: rtl/imem_fetch_sequencer_if.sv
// Bus between the fetch sequencer, the instruction memory read port and the decoder.
// The master modport is the sequencer's view; the slave modport is the environment's.
interface imem_fetch_sequencer_if #(
   parameter int INST_DATA_WIDTH = 32,
   parameter int INST_ADDR_WIDTH = 10
) ();

   logic                       imem_block_ready;
   logic                       imem_rd_req;
   logic [INST_ADDR_WIDTH-1:0] imem_rd_addr;
   logic [INST_DATA_WIDTH-1:0] imem_rd_data;
   logic                       imem_rd_valid;
   logic                       imem_rd_block_done;
   logic                       inst_valid;
   logic [INST_DATA_WIDTH-1:0] inst_data;
   logic                       inst_ready;

   modport master (
      input  imem_block_ready, imem_rd_data, imem_rd_valid, inst_ready,
      output imem_rd_req, imem_rd_addr, imem_rd_block_done, inst_valid, inst_data
   );

   modport slave (
      output imem_block_ready, imem_rd_data, imem_rd_valid, inst_ready,
      input  imem_rd_req, imem_rd_addr, imem_rd_block_done, inst_valid, inst_data
   );

endinterface

// File: rtl/imem_fetch_fifo.sv
// Show-ahead synchronous FIFO: the head word is visible on o_data whenever not empty.
// Pointers and count are reset/flushed; the storage array holds data only.
module imem_fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_occ
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [PW:0]      r_cnt;
   logic             w_wr;
   logic             w_rd;

   assign w_wr = i_push && !i_flush && (r_cnt != (PW+1)'(DEPTH));
   assign w_rd = i_pop && !i_flush && (r_cnt != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_wr, w_rd})
            2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_empty = (r_cnt == '0);
   assign o_occ   = r_cnt;

endmodule

// File: rtl/imem_fetch_sequencer.sv
// Read-side controller for the double-buffered instruction memory: fetches one block
// sequentially under FIFO credit control, stops at the block-end opcode, drains, then signals done.
module imem_fetch_sequencer
   import genesys_imem_pkg::*;
#(
   parameter int INST_DATA_WIDTH = 32,
   parameter int INST_ADDR_WIDTH = 10,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   genesys_done,
   imem_fetch_sequencer_if.master bus,
   output logic                   busy,
   output logic                   addr_overflow,
   output logic [15:0]            blocks_done
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [INST_ADDR_WIDTH-1:0] ADDR_MAX = '1;

   imem_seq_state_e             r_state;
   imem_seq_state_e             w_next;
   logic [INST_ADDR_WIDTH-1:0]  r_addr;
   logic                        r_end_seen;
   logic                        r_outstanding;
   logic                        r_overflow;
   logic [15:0]                 r_blocks_done;

   logic                        w_abort;
   logic                        w_enter_fetch;
   logic                        w_credit_ok;
   logic                        w_req;
   logic                        w_push;
   logic                        w_end_word;
   logic                        w_pop;
   logic                        w_empty;
   logic [CW-1:0]               w_occ;
   logic [INST_DATA_WIDTH-1:0]  w_head;

   assign w_abort = genesys_done &&
                    (r_state == ST_WAIT_BLK || r_state == ST_FETCH || r_state == ST_DRAIN);
   assign w_enter_fetch = (r_state == ST_WAIT_BLK) && (w_next == ST_FETCH);

   // A read in flight already owns a FIFO slot, so it counts against the credit.
   assign w_credit_ok = (w_occ + CW'(r_outstanding)) < CW'(FIFO_DEPTH);
   assign w_req       = (r_state == ST_FETCH) && !r_end_seen && !w_abort && w_credit_ok;
   assign w_push      = bus.imem_rd_valid && (r_state == ST_FETCH) && !r_end_seen && !w_abort;
   assign w_end_word  = w_push && is_block_end(bus.imem_rd_data[OPCODE_LSB +: OPCODE_W]);
   assign w_pop       = !w_empty && bus.inst_ready;

   imem_fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (INST_DATA_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .i_flush (w_abort),
      .i_push  (w_push),
      .i_data  (bus.imem_rd_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_empty (w_empty),
      .o_occ   (w_occ)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:     if (start && !genesys_done) w_next = ST_WAIT_BLK;
         ST_WAIT_BLK: if (w_abort) w_next = ST_IDLE;
                      else if (bus.imem_block_ready) w_next = ST_FETCH;
         ST_FETCH:    if (w_abort) w_next = ST_IDLE;
                      else if (r_end_seen && !r_outstanding) w_next = ST_DRAIN;
         ST_DRAIN:    if (w_abort) w_next = ST_IDLE;
                      else if (w_empty) w_next = ST_DONE;
         ST_DONE:     w_next = genesys_done ? ST_IDLE : ST_WAIT_BLK;
         default:     w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr        <= '0;
         r_end_seen    <= 1'b0;
         r_outstanding <= 1'b0;
         r_overflow    <= 1'b0;
         r_blocks_done <= '0;
      end else begin
         if (w_enter_fetch) begin
            r_addr        <= '0;
            r_end_seen    <= 1'b0;
            r_outstanding <= 1'b0;
         end else begin
            // The last address never wraps: it closes the block and flags the overflow.
            if (w_req) begin
               if (r_addr == ADDR_MAX) begin
                  r_end_seen <= 1'b1;
                  r_overflow <= 1'b1;
               end else begin
                  r_addr <= r_addr + INST_ADDR_WIDTH'(1);
               end
            end
            if (w_end_word) r_end_seen <= 1'b1;
            if (w_abort)                r_outstanding <= 1'b0;
            else if (w_req)             r_outstanding <= 1'b1;
            else if (bus.imem_rd_valid) r_outstanding <= 1'b0;
         end
         if (r_state == ST_DONE) r_blocks_done <= r_blocks_done + 16'd1;
      end
   end

   always_comb begin
      bus.imem_rd_req        = w_req;
      bus.imem_rd_addr       = r_addr;
      bus.imem_rd_block_done = (r_state == ST_DONE);
      bus.inst_valid         = !w_empty;
      bus.inst_data          = w_empty ? '0 : w_head;
      busy                   = (r_state != ST_IDLE);
      addr_overflow          = r_overflow;
      blocks_done            = r_blocks_done;
   end

endmodule
